pad_ctrl: RTL and testbench

PAD_CTRL -- requirements
Module: pad_ctrl

---
 rtl/pad_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pad_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_ctrl.sv
// ---------------------------------------------------------------------------
// pad_ctrl -- register-mapped controller for a bank of bidirectional pads.
//
// A small single-cycle register bus configures the pad cell controls
// (output value, output enable, pull-up/down, slew, drive strength). The
// bus also reads back the synchronised pad inputs and services per-pad edge
// interrupts.
//
// Register map (word index on bus_addr):
//   0 OUT       1 OE        2 PU        3 PD        4 SL        5 CS
//   6 IN (RO)   7 IRQ_MASK  8 IRQ_EDGE (0=rise, 1=fall)
//   9 IRQ_PEND (write-1-to-clear)
//   A OUT_SET (write-1-to-set OUT, reads 0)
//   B OUT_CLR (write-1-to-clear OUT, reads 0)
//   C ALT (only with PAD_CTRL_ALTFUNC_EN; otherwise reads 0, writes ignored)
// Unmapped addresses and bits at or above NUM_PADS read 0 and ignore writes.
//
// Optional feature macro: PAD_CTRL_ALTFUNC_EN
//   When defined, the ALT register and the alt_out/alt_oe/alt_in ports are
//   present. ALT[i]=1 hands pad_out[i]/pad_oe[i] to the alternate function.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   bus_req/bus_we      request strobe and write select (1=write)
//   bus_addr[3:0]       register word index
//   bus_wdata[31:0]     write data
//   bus_rdata[31:0]     read data, valid while bus_ack=1, otherwise 0
//   bus_ack             one-cycle completion pulse, one cycle after bus_req
//   pad_out/oe/ie/pu/pd/sl/cs [NUM_PADS-1:0]  pad cell controls
//   pad_in[NUM_PADS-1:0] raw asynchronous pad inputs
//   irq                 level interrupt, OR of pending & mask (registered)
//   alt_out/alt_oe      alternate-function drive (macro only)
//   alt_in              synchronised pad inputs for the alternate function
// ---------------------------------------------------------------------------
module pad_ctrl #(
  parameter int NUM_PADS    = 18,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bus_req,
  input  logic                bus_we,
  input  logic [3:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_ack,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_ie,
  output logic [NUM_PADS-1:0] pad_pu,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic [NUM_PADS-1:0] pad_sl,
  output logic [NUM_PADS-1:0] pad_cs,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic                irq
`ifdef PAD_CTRL_ALTFUNC_EN
  ,
  input  logic [NUM_PADS-1:0] alt_out,
  input  logic [NUM_PADS-1:0] alt_oe,
  output logic [NUM_PADS-1:0] alt_in
`endif
);

  localparam int DATA_W = 32;

  localparam logic [3:0] A_OUT  = 4'h0;
  localparam logic [3:0] A_OE   = 4'h1;
  localparam logic [3:0] A_PU   = 4'h2;
  localparam logic [3:0] A_PD   = 4'h3;
  localparam logic [3:0] A_SL   = 4'h4;
  localparam logic [3:0] A_CS   = 4'h5;
  localparam logic [3:0] A_IN   = 4'h6;
  localparam logic [3:0] A_MASK = 4'h7;
  localparam logic [3:0] A_EDGE = 4'h8;
  localparam logic [3:0] A_PEND = 4'h9;
  localparam logic [3:0] A_SET  = 4'hA;
  localparam logic [3:0] A_CLR  = 4'hB;
`ifdef PAD_CTRL_ALTFUNC_EN
  localparam logic [3:0] A_ALT  = 4'hC;
`endif

  // Zero-extend a pad-wide vector onto the 32-bit bus.
  function automatic logic [DATA_W-1:0] pad_zext(input logic [NUM_PADS-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[NUM_PADS-1:0] = v;
    return r;
  endfunction

  // Register state
  logic [NUM_PADS-1:0] out_q, oe_q, pu_q, pd_q, sl_q, cs_q;
  logic [NUM_PADS-1:0] mask_q, edge_q, pend_q;
`ifdef PAD_CTRL_ALTFUNC_EN
  logic [NUM_PADS-1:0] alt_q;
  logic [NUM_PADS-1:0] alt_nxt;
`endif

  // Input synchroniser and edge history
  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] hist_q;
  logic                hist_vld_q;
  logic [NUM_PADS-1:0] in_sync;

  // Bus response stage
  logic                ack_p1;
  logic [DATA_W-1:0]   rdata_p1;
  logic                irq_q;

  // Next-state values
  logic [NUM_PADS-1:0] out_nxt, oe_nxt, pu_nxt, pd_nxt, sl_nxt, cs_nxt;
  logic [NUM_PADS-1:0] mask_nxt, edge_nxt, pend_nxt;
  logic [NUM_PADS-1:0] w1c, rise, fall, evt;
  logic [DATA_W-1:0]   rd_val;
  logic [NUM_PADS-1:0] wr_data;
  logic                wr_en;

  // Bits of bus_wdata above NUM_PADS carry no state; fold them here so the
  // whole port is consumed.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata;

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign wr_data = bus_wdata[NUM_PADS-1:0];
  assign wr_en   = bus_req & bus_we;

  // Read mux: value of the addressed register before this cycle's write.
  always_comb begin
    rd_val = '0;
    case (bus_addr)
      A_OUT:  rd_val = pad_zext(out_q);
      A_OE:   rd_val = pad_zext(oe_q);
      A_PU:   rd_val = pad_zext(pu_q);
      A_PD:   rd_val = pad_zext(pd_q);
      A_SL:   rd_val = pad_zext(sl_q);
      A_CS:   rd_val = pad_zext(cs_q);
      A_IN:   rd_val = pad_zext(in_sync);
      A_MASK: rd_val = pad_zext(mask_q);
      A_EDGE: rd_val = pad_zext(edge_q);
      A_PEND: rd_val = pad_zext(pend_q);
`ifdef PAD_CTRL_ALTFUNC_EN
      A_ALT:  rd_val = pad_zext(alt_q);
`endif
      default: rd_val = '0;
    endcase
  end

  // Register write decode. OUT, OUT_SET and OUT_CLR share one address
  // decoder so at most one of them can touch OUT in a cycle.
  always_comb begin
    out_nxt  = out_q;
    oe_nxt   = oe_q;
    pu_nxt   = pu_q;
    pd_nxt   = pd_q;
    sl_nxt   = sl_q;
    cs_nxt   = cs_q;
    mask_nxt = mask_q;
    edge_nxt = edge_q;
    w1c      = '0;
`ifdef PAD_CTRL_ALTFUNC_EN
    alt_nxt  = alt_q;
`endif
    if (wr_en) begin
      case (bus_addr)
        A_OUT:  out_nxt  = wr_data;
        A_OE:   oe_nxt   = wr_data;
        A_PU:   pu_nxt   = wr_data;
        A_PD:   pd_nxt   = wr_data;
        A_SL:   sl_nxt   = wr_data;
        A_CS:   cs_nxt   = wr_data;
        A_MASK: mask_nxt = wr_data;
        A_EDGE: edge_nxt = wr_data;
        A_PEND: w1c      = wr_data;
        A_SET:  out_nxt  = out_q | wr_data;
        A_CLR:  out_nxt  = out_q & ~wr_data;
`ifdef PAD_CTRL_ALTFUNC_EN
        A_ALT:  alt_nxt  = wr_data;
`endif
        default: ;
      endcase
    end
  end

  // Edge detection on the synchronised inputs. The first cycle after reset
  // is masked so history left from before reset can never raise an event.
  always_comb begin
    rise     = in_sync & ~hist_q;
    fall     = ~in_sync & hist_q;
    evt      = hist_vld_q ? ((rise & ~edge_q) | (fall & edge_q)) : '0;
    // A new event wins over a same-cycle clear of the same bit.
    pend_nxt = (pend_q & ~w1c) | evt;
  end

  // Stage p0 -> p1: register update, bus response, synchroniser shift
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      oe_q       <= '0;
      pu_q       <= '0;
      pd_q       <= '0;
      sl_q       <= '0;
      cs_q       <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
`ifdef PAD_CTRL_ALTFUNC_EN
      alt_q      <= '0;
`endif
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      ack_p1     <= 1'b0;
      rdata_p1   <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_nxt;
      oe_q       <= oe_nxt;
      pu_q       <= pu_nxt;
      pd_q       <= pd_nxt;
      sl_q       <= sl_nxt;
      cs_q       <= cs_nxt;
      mask_q     <= mask_nxt;
      edge_q     <= edge_nxt;
      pend_q     <= pend_nxt;
`ifdef PAD_CTRL_ALTFUNC_EN
      alt_q      <= alt_nxt;
`endif
      sync_q[0]  <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q     <= in_sync;
      hist_vld_q <= 1'b1;
      ack_p1     <= bus_req;
      rdata_p1   <= bus_req ? rd_val : '0;
      // irq tracks the post-update pending and mask state in the same edge.
      irq_q      <= |(pend_nxt & mask_nxt);
    end
  end

  // Output assignment
  assign bus_ack   = ack_p1;
  assign bus_rdata = rdata_p1;
  assign irq       = irq_q;
  assign pad_pu    = pu_q;
  assign pad_pd    = pd_q;
  assign pad_sl    = sl_q;
  assign pad_cs    = cs_q;

`ifdef PAD_CTRL_ALTFUNC_EN
  // Alternate function bypasses the OUT/OE flops per pad.
  assign pad_out = (alt_q & alt_out) | (~alt_q & out_q);
  assign pad_oe  = (alt_q & alt_oe)  | (~alt_q & oe_q);
  assign alt_in  = in_sync;
`else
  assign pad_out = out_q;
  assign pad_oe  = oe_q;
`endif

  // Input buffer is enabled whenever the output driver is off.
  assign pad_ie = ~pad_oe;

endmodule

// File: tb/tb_pad_ctrl.sv
module tb_pad_ctrl;

  localparam int NP = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_req, bus_we;
  logic [3:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic [NP-1:0] pad_out, pad_oe, pad_ie, pad_pu, pad_pd, pad_sl, pad_cs;
  logic [NP-1:0] pad_in;
  logic          irq;
`ifdef PAD_CTRL_ALTFUNC_EN
  logic [NP-1:0] alt_out, alt_oe, alt_in;
`endif

  pad_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .pad_ie    (pad_ie),
    .pad_pu    (pad_pu),
    .pad_pd    (pad_pd),
    .pad_sl    (pad_sl),
    .pad_cs    (pad_cs),
    .pad_in    (pad_in),
    .irq       (irq)
`ifdef PAD_CTRL_ALTFUNC_EN
    ,
    .alt_out   (alt_out),
    .alt_oe    (alt_oe),
    .alt_in    (alt_in)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_req = 1'b0;
    bus_we  = 1'b0;
  endtask

  task automatic issue_wr(input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    e.is_rd = 1'b0; e.exp = '0;
    sb.push_back(e);
  endtask

  task automatic issue_rd(input logic [3:0] a, input logic [31:0] exp);
    exp_t e;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = '0;
    e.is_rd = 1'b1; e.exp = exp;
    sb.push_back(e);
  endtask

  // Check the response for the oldest outstanding request.
  task automatic complete(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, observed ack %0b required an outstanding request", tag, bus_ack);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ack"}, {31'b0, bus_ack}, 32'h1);
      if (e.is_rd) chk({tag, "_rdata"}, bus_rdata, e.exp);
    end
  endtask

  task automatic wr(input string tag, input logic [3:0] a, input logic [31:0] d);
    issue_wr(a, d);
    tick();
    idle();
    complete(tag);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    issue_rd(a, exp);
    tick();
    idle();
    complete(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    pad_in = '0;
`ifdef PAD_CTRL_ALTFUNC_EN
    alt_out = '0; alt_oe = '0;
`endif
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ack",   {31'b0, bus_ack}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_irq",   {31'b0, irq}, 32'h0);
    chk("rst_ie",    32'(pad_ie), 32'h3FFFF);
    chk("rst_oe",    32'(pad_oe), 32'h0);
    chk("rst_out",   32'(pad_out), 32'h0);
    tick();
    chk("idle_ack",  {31'b0, bus_ack}, 32'h0);

    // OE / OUT writes, visible in the ack cycle
    wr("wr_oe", 4'h1, 32'h0000F);
    chk("pad_oe", 32'(pad_oe), 32'h0000F);
    chk("pad_ie", 32'(pad_ie), 32'h3FFF0);
    wr("wr_out", 4'h0, 32'h00005);
    chk("pad_out", 32'(pad_out), 32'h00005);

    // Back-to-back reads
    issue_rd(4'h1, 32'h0000F);
    tick();
    issue_rd(4'h0, 32'h00005);
    complete("b2b_oe");
    tick();
    idle();
    complete("b2b_out");
    tick();
    chk("b2b_noack", {31'b0, bus_ack}, 32'h0);
    chk("b2b_rdata0", bus_rdata, 32'h0);

    // OUT_SET / OUT_CLR
    wr("wr_out_f0", 4'h0, 32'h000F0);
    wr("wr_set",    4'hA, 32'h00003);
    wr("wr_clr",    4'hB, 32'h00010);
    rd("rd_out_e3", 4'h0, 32'h000E3);
    chk("pad_out_e3", 32'(pad_out), 32'h000E3);
    rd("rd_set0", 4'hA, 32'h0);
    rd("rd_clr0", 4'hB, 32'h0);

    // Other control registers and width / address boundaries
    wr("wr_pu", 4'h2, 32'hFFFFFFFF);
    chk("pad_pu", 32'(pad_pu), 32'h3FFFF);
    rd("rd_pu", 4'h2, 32'h3FFFF);
    wr("wr_pd", 4'h3, 32'h00A5A);
    chk("pad_pd", 32'(pad_pd), 32'h00A5A);
    wr("wr_sl", 4'h4, 32'h20001);
    chk("pad_sl", 32'(pad_sl), 32'h20001);
    wr("wr_cs", 4'h5, 32'h12345);
    chk("pad_cs", 32'(pad_cs), 32'h12345);
    rd("rd_cs", 4'h5, 32'h12345);
    wr("wr_d", 4'hD, 32'hFFFFFFFF);
    rd("rd_d", 4'hD, 32'h0);
    rd("rd_f", 4'hF, 32'h0);
`ifndef PAD_CTRL_ALTFUNC_EN
    wr("wr_c", 4'hC, 32'hFFFFFFFF);
    rd("rd_c", 4'hC, 32'h0);
`endif
    wr("wr_in_ro", 4'h6, 32'hFFFFFFFF);
    rd("rd_in0", 4'h6, 32'h0);

    // Rising edge on pad 3 with mask bit 3
    wr("wr_edge0", 4'h8, 32'h0);
    wr("wr_mask8", 4'h7, 32'h8);
    pad_in[3] = 1'b1;
    tick();                       // edge 1
    chk("e1_irq", {31'b0, irq}, 32'h0);
    issue_rd(4'h6, 32'h0);
    tick();                       // edge 2
    complete("in_e1");
    chk("e2_irq", {31'b0, irq}, 32'h0);
    issue_rd(4'h6, 32'h8);
    tick();                       // edge 3
    idle();
    complete("in_e2");
    chk("e3_irq", {31'b0, irq}, 32'h1);
    rd("rd_pend8", 4'h9, 32'h8);
    wr("w1c_8", 4'h9, 32'h8);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    rd("rd_pend0", 4'h9, 32'h0);

    // Falling edge select; mask writes leave pending bits alone
    wr("wr_edge8", 4'h8, 32'h8);
    pad_in[3] = 1'b0;
    tick(); tick(); tick();
    chk("fall_irq", {31'b0, irq}, 32'h1);
    rd("rd_pend_fall", 4'h9, 32'h8);
    wr("wr_mask0", 4'h7, 32'h0);
    chk("mask0_irq", {31'b0, irq}, 32'h0);
    rd("rd_pend_kept", 4'h9, 32'h8);
    wr("wr_mask8b", 4'h7, 32'h8);
    chk("mask8_irq", {31'b0, irq}, 32'h1);
    wr("w1c_8b", 4'h9, 32'h8);
    chk("w1c_irq_b", {31'b0, irq}, 32'h0);
    wr("wr_edge0b", 4'h8, 32'h0);

    // Set event in the same cycle as W1C of the same bit
    pad_in[2] = 1'b1;
    tick(); tick();
    issue_wr(4'h9, 32'h4);
    tick();                       // event edge
    idle();
    complete("w1c_race");
    rd("rd_pend_race", 4'h9, 32'h4);
    chk("race_irq_masked", {31'b0, irq}, 32'h0);
    wr("wr_mask4", 4'h7, 32'h4);
    chk("race_irq", {31'b0, irq}, 32'h1);

`ifdef PAD_CTRL_ALTFUNC_EN
    // Alternate function override on pad 0
    wr("alt_out0", 4'h0, 32'h0);
    wr("alt_oe0",  4'h1, 32'h0);
    alt_out[0] = 1'b1;
    alt_oe[0]  = 1'b1;
    wr("wr_alt1", 4'hC, 32'h1);
    chk("alt_pad_out", {31'b0, pad_out[0]}, 32'h1);
    chk("alt_pad_oe",  {31'b0, pad_oe[0]}, 32'h1);
    chk("alt_pad_ie",  {31'b0, pad_ie[0]}, 32'h0);
    rd("rd_alt1", 4'hC, 32'h1);
    wr("wr_alt0", 4'hC, 32'h0);
    chk("noalt_pad_out", {31'b0, pad_out[0]}, 32'h0);
    chk("noalt_pad_oe",  {31'b0, pad_oe[0]}, 32'h0);
    alt_out = '0;
    alt_oe  = '0;
`endif

    // Reset coincident with a write request
    pad_in = '0;
    tick(); tick(); tick();
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'hFF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rr_ack",   {31'b0, bus_ack}, 32'h0);
    chk("rr_rdata", bus_rdata, 32'h0);
    chk("rr_out",   32'(pad_out), 32'h0);
    chk("rr_oe",    32'(pad_oe), 32'h0);
    chk("rr_ie",    32'(pad_ie), 32'h3FFFF);
    chk("rr_pu",    32'(pad_pu), 32'h0);
    chk("rr_irq",   {31'b0, irq}, 32'h0);
    tick();
    chk("rr_ack2",  {31'b0, bus_ack}, 32'h0);
    chk("rr_out2",  32'(pad_out), 32'h0);
    rd("rr_rd_out",  4'h0, 32'h0);
    rd("rr_rd_mask", 4'h7, 32'h0);
    rd("rr_rd_pend", 4'h9, 32'h0);
    chk("rr_sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
